// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2R/1W register file, r0 = 0, pending-write scoreboard; `REGFILE_BYPASS_EN adds write-through forwarding
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_writeEnable,
  input  logic [AW-1:0]    ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic             ctrl_markPending,
  input  logic [AW-1:0]    ctrl_pendingReg,
  input  logic [AW-1:0]    ctrl_readRegA,
  input  logic [AW-1:0]    ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB,
  output logic             stall_A,
  output logic             stall_B,
  output logic             pending_any
);
  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0] r_pend;
  logic             w_wr;
  logic             w_mk;
  assign w_wr = ctrl_writeEnable && (ctrl_writeReg != '0);
  assign w_mk = ctrl_markPending && (ctrl_pendingReg != '0);
  // entry 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_regs <= '{default: '0};
      r_pend <= '0;
    end else begin
      if (w_wr) begin
        r_regs[ctrl_writeReg] <= data_writeReg;
        r_pend[ctrl_writeReg] <= 1'b0;
      end
      if (w_mk) r_pend[ctrl_pendingReg] <= 1'b1;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic w_fwd_a, w_fwd_b;
  assign w_fwd_a = w_wr && (ctrl_readRegA == ctrl_writeReg);
  assign w_fwd_b = w_wr && (ctrl_readRegB == ctrl_writeReg);
  assign data_readRegA = w_fwd_a ? data_writeReg : r_regs[ctrl_readRegA];
  assign data_readRegB = w_fwd_b ? data_writeReg : r_regs[ctrl_readRegB];
  assign stall_A = w_fwd_a ? (w_mk && ctrl_pendingReg == ctrl_readRegA) : r_pend[ctrl_readRegA];
  assign stall_B = w_fwd_b ? (w_mk && ctrl_pendingReg == ctrl_readRegB) : r_pend[ctrl_readRegB];
`else
  assign data_readRegA = r_regs[ctrl_readRegA];
  assign data_readRegB = r_regs[ctrl_readRegB];
  assign stall_A = r_pend[ctrl_readRegA];
  assign stall_B = r_pend[ctrl_readRegB];
`endif
  assign pending_any = |r_pend;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed + random stimulus against an array-based reference model
module tb_regfile_scoreboard;
  logic        clock = 0;
  logic        ctrl_reset_n = 0;
  logic        ctrl_writeEnable = 0;
  logic [4:0]  ctrl_writeReg = 0;
  logic [31:0] data_writeReg = 0;
  logic        ctrl_markPending = 0;
  logic [4:0]  ctrl_pendingReg = 0;
  logic [4:0]  ctrl_readRegA = 0;
  logic [4:0]  ctrl_readRegB = 0;
  logic [31:0] data_readRegA, data_readRegB;
  logic        stall_A, stall_B, pending_any;
  logic [31:0] mdl_reg [32];
  bit          mdl_pend [32];
  int          n_chk = 0;
  int          n_pass = 0;
  regfile_scoreboard dut (
    .clock(clock), .ctrl_reset_n(ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_markPending(ctrl_markPending), .ctrl_pendingReg(ctrl_pendingReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .stall_A(stall_A), .stall_B(stall_B), .pending_any(pending_any)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
  endtask
  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) begin
      mdl_reg[i] = 0;
      mdl_pend[i] = 0;
    end
  endtask
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeEnable && ctrl_writeReg == a) return data_writeReg;
`endif
    return mdl_reg[a];
  endfunction
  function automatic logic [31:0] exp_stall(input logic [4:0] a);
    if (a == 0) return 0;
`ifdef REGFILE_BYPASS_EN
    if (ctrl_writeEnable && ctrl_writeReg == a) return {31'b0, ctrl_markPending && ctrl_pendingReg == a};
`endif
    return {31'b0, mdl_pend[a]};
  endfunction
  function automatic logic [31:0] exp_any();
    for (int i = 1; i < 32; i++) if (mdl_pend[i]) return 1;
    return 0;
  endfunction
  task automatic check_outputs();
    chk("rdA", data_readRegA, exp_data(ctrl_readRegA));
    chk("rdB", data_readRegB, exp_data(ctrl_readRegB));
    chk("stallA", {31'b0, stall_A}, exp_stall(ctrl_readRegA));
    chk("stallB", {31'b0, stall_B}, exp_stall(ctrl_readRegB));
    chk("pend_any", {31'b0, pending_any}, exp_any());
  endtask
  // drive in the low phase, check before the edge, apply the edge to the model
  task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic mk, input logic [4:0] pr, input logic [4:0] ra, input logic [4:0] rb);
    ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
    ctrl_markPending = mk; ctrl_pendingReg = pr;
    ctrl_readRegA = ra; ctrl_readRegB = rb;
    #1;
    check_outputs();
    @(posedge clock);
    if (we && wr != 0) begin
      mdl_reg[wr] = wd;
      mdl_pend[wr] = 0;
    end
    if (mk && pr != 0) mdl_pend[pr] = 1;
    @(negedge clock);
  endtask
  task automatic idle_read(input logic [4:0] ra, input logic [4:0] rb);
    step(0, 0, 0, 0, 0, ra, rb);
  endtask
  initial begin
    mdl_clear();
    ctrl_readRegA = 5;
    ctrl_readRegB = 9;
    #1;
    check_outputs();
    @(negedge clock);
    ctrl_reset_n = 1;
    step(1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    step(1, 0, 32'h12345678, 0, 0, 5, 0);
    idle_read(5, 0);
    step(0, 0, 0, 1, 7, 7, 5);
    step(1, 7, 32'h0000002A, 0, 0, 7, 5);
    idle_read(7, 0);
    step(1, 9, 32'h11112222, 1, 9, 9, 7);
    step(1, 4, 32'h44444444, 1, 3, 9, 3);
    idle_read(3, 4);
    step(0, 0, 0, 1, 3, 3, 9);
    step(1, 12, 32'h0BADF00D, 0, 0, 12, 0);
    step(1, 12, 32'hCAFEF00D, 0, 0, 12, 12);
    step(1, 12, 32'h5A5A5A5A, 1, 12, 12, 3);
    idle_read(12, 9);
    // asynchronous reset asserted while the clock is high, checked before any edge
    @(posedge clock);
    #2;
    ctrl_reset_n = 0;
    mdl_clear();
    ctrl_readRegA = 5;
    ctrl_readRegB = 9;
    #1;
    check_outputs();
    @(negedge clock);
    check_outputs();
    ctrl_reset_n = 1;
    for (int i = 1; i < 32; i++) step(1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 5'(i), 5'(i - 1));
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) idle_read(5'(i), 5'(j));
    step(0, 0, 0, 1, 0, 0, 0);
    idle_read(0, 0);
    for (int k = 0; k < 400; k++) begin
      logic [4:0] wr, pr, ra, rb;
      wr = 5'($urandom_range(0, 31));
      pr = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      ra = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 2) == 0) ? pr : 5'($urandom_range(0, 31));
      step(1'($urandom_range(0, 1)), wr, $urandom, ($urandom_range(0, 3) == 0), pr, ra, rb);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
